ram8k_arbiter: RTL and testbench

RAM8K_ARBITER -- requirements
Module: ram8k_arbiter

---
 rtl/ram8k_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_ram8k_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram8k_arbiter.sv
// Two-port arbiter sharing one asynchronous SRAM between a CPU (read/write)
// and a PPU (read-only). Round-robin on ties, fully registered outputs.
module ram8k_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ppu_req,
    input  logic [ADDR_WIDTH-1:0] ppu_addr,
    output logic                  ppu_ack,
    output logic [DATA_WIDTH-1:0] ppu_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_wdata_en,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2,
        WR      = 2'd3
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    owner_ppu;
    logic                    owner_ppu_nxt;
    logic                    last_ppu;
    logic                    last_ppu_nxt;
    logic [ADDR_WIDTH-1:0]   addr_lat;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]   wdata_lat;
    logic [DATA_WIDTH-1:0]   wdata_nxt;
    logic                    cpu_elig;
    logic                    ppu_elig;
    logic                    grant_cpu;
    logic                    grant_ppu;

    logic [ADDR_WIDTH-1:0]   ram_addr_nxt;
    logic                    ram_cs_nxt;
    logic                    ram_we_nxt;
    logic                    ram_oe_nxt;
    logic [DATA_WIDTH-1:0]   ram_wdata_nxt;
    logic                    ram_wdata_en_nxt;
    logic                    busy_nxt;
    logic                    cpu_ack_nxt;
    logic                    ppu_ack_nxt;
    logic [DATA_WIDTH-1:0]   cpu_rdata_nxt;
    logic [DATA_WIDTH-1:0]   ppu_rdata_nxt;

    // A requester whose ack is high this cycle is finishing, so it is not eligible
    assign cpu_elig = cpu_req & ~cpu_ack;
    assign ppu_elig = ppu_req & ~ppu_ack;

    // State register plus latched request (owner, address, write data, last grant)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_ppu <= 1'b0;
            last_ppu  <= 1'b0;
            addr_lat  <= '0;
            wdata_lat <= '0;
        end else begin
            state     <= next_state;
            owner_ppu <= owner_ppu_nxt;
            last_ppu  <= last_ppu_nxt;
            addr_lat  <= addr_nxt;
            wdata_lat <= wdata_nxt;
        end
    end

    // Next-state and grant decision
    always_comb begin
        next_state    = state;
        owner_ppu_nxt = owner_ppu;
        last_ppu_nxt  = last_ppu;
        addr_nxt      = addr_lat;
        wdata_nxt     = wdata_lat;
        grant_cpu     = 1'b0;
        grant_ppu     = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_elig && ppu_elig) begin
                    if (last_ppu) begin
                        grant_cpu = 1'b1;
                    end else begin
                        grant_ppu = 1'b1;
                    end
                end else if (cpu_elig) begin
                    grant_cpu = 1'b1;
                end else if (ppu_elig) begin
                    grant_ppu = 1'b1;
                end else begin
                    next_state = IDLE;
                end

                if (grant_cpu) begin
                    owner_ppu_nxt = 1'b0;
                    last_ppu_nxt  = 1'b0;
                    addr_nxt      = cpu_addr;
                    wdata_nxt     = cpu_we ? cpu_wdata : '0;
                    next_state    = cpu_we ? WR : RD_ADDR;
                end else if (grant_ppu) begin
                    owner_ppu_nxt = 1'b1;
                    last_ppu_nxt  = 1'b1;
                    addr_nxt      = ppu_addr;
                    wdata_nxt     = '0;
                    next_state    = RD_ADDR;
                end else begin
                    next_state = IDLE;
                end
            end
            RD_ADDR: next_state = RD_DATA;
            RD_DATA: next_state = IDLE;
            WR:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: RAM strobes follow the state being entered so they are
    // registered yet line up with that state; acks/rdata follow the state being left
    always_comb begin
        ram_cs_nxt       = 1'b0;
        ram_we_nxt       = 1'b0;
        ram_oe_nxt       = 1'b0;
        ram_wdata_en_nxt = 1'b0;
        ram_addr_nxt     = '0;
        ram_wdata_nxt    = '0;
        busy_nxt         = 1'b0;
        case (next_state)
            RD_ADDR: begin
                ram_cs_nxt   = 1'b1;
                ram_addr_nxt = addr_nxt;
                busy_nxt     = 1'b1;
            end
            RD_DATA: begin
                ram_cs_nxt   = 1'b1;
                ram_oe_nxt   = 1'b1;
                ram_addr_nxt = addr_nxt;
                busy_nxt     = 1'b1;
            end
            WR: begin
                ram_cs_nxt       = 1'b1;
                ram_we_nxt       = 1'b1;
                ram_wdata_en_nxt = 1'b1;
                ram_addr_nxt     = addr_nxt;
                ram_wdata_nxt    = wdata_nxt;
                busy_nxt         = 1'b1;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase

        cpu_ack_nxt   = 1'b0;
        ppu_ack_nxt   = 1'b0;
        cpu_rdata_nxt = cpu_rdata;
        ppu_rdata_nxt = ppu_rdata;
        case (state)
            RD_DATA: begin
                if (owner_ppu) begin
                    ppu_ack_nxt   = 1'b1;
                    ppu_rdata_nxt = ram_rdata;
                end else begin
                    cpu_ack_nxt   = 1'b1;
                    cpu_rdata_nxt = ram_rdata;
                end
            end
            WR: begin
                cpu_ack_nxt = 1'b1;
            end
            default: begin
                cpu_ack_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr     <= '0;
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
            ram_oe       <= 1'b0;
            ram_wdata    <= '0;
            ram_wdata_en <= 1'b0;
            busy         <= 1'b0;
            cpu_ack      <= 1'b0;
            ppu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            ppu_rdata    <= '0;
        end else begin
            ram_addr     <= ram_addr_nxt;
            ram_cs       <= ram_cs_nxt;
            ram_we       <= ram_we_nxt;
            ram_oe       <= ram_oe_nxt;
            ram_wdata    <= ram_wdata_nxt;
            ram_wdata_en <= ram_wdata_en_nxt;
            busy         <= busy_nxt;
            cpu_ack      <= cpu_ack_nxt;
            ppu_ack      <= ppu_ack_nxt;
            cpu_rdata    <= cpu_rdata_nxt;
            ppu_rdata    <= ppu_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_ram8k_arbiter.sv
// Directed bench for ram8k_arbiter with a behavioural SRAM on the RAM port.
module tb_ram8k_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          ppu_req = 1'b0;
    logic [AW-1:0] ppu_addr = '0;
    logic          ppu_ack;
    logic [DW-1:0] ppu_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;
    logic [DW-1:0] ram_wdata;
    logic          ram_wdata_en;
    logic [DW-1:0] ram_rdata;
    logic          busy;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    ram8k_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_wdata(ram_wdata), .ram_wdata_en(ram_wdata_en), .ram_rdata(ram_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: combinational read when selected and output-enabled
    assign ram_rdata = (ram_cs && ram_oe) ? mem[ram_addr] : 8'h00;

    always @(posedge clk) begin
        if (ram_cs && ram_we && ram_wdata_en) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus-safety properties checked every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            chk("no_contention", 32'(ram_oe & ram_wdata_en), 32'd0);
            chk("cs_when_idle", 32'(ram_cs & ~busy), 32'd0);
        end
    end

    // Single access on one port: checks latency, read data and one-cycle ack
    task automatic access(input bit is_ppu, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int exp_lat,
                          input logic [DW-1:0] exp_rd, input string tag);
        int n;
        bit got;
        if (is_ppu) begin
            ppu_req = 1'b1;
            ppu_addr = a;
        end else begin
            cpu_req = 1'b1;
            cpu_we = we;
            cpu_addr = a;
            cpu_wdata = d;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            got = is_ppu ? ppu_ack : cpu_ack;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        if (!we) begin
            chk({tag, "_rdata"}, 32'(is_ppu ? ppu_rdata : cpu_rdata), 32'(exp_rd));
        end
        cpu_req = 1'b0;
        ppu_req = 1'b0;
        tick();
        chk({tag, "_ack_one_cycle"}, 32'(is_ppu ? ppu_ack : cpu_ack), 32'd0);
    endtask

    initial begin
        int ppu_cyc;
        int cpu_cyc;
        int cnt;
        int kinds [8];
        int times [8];
        int n;

        // Reset state
        tick();
        tick();
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_ppu_ack", 32'(ppu_ack), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_ppu_rdata", 32'(ppu_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_strobes", 32'({ram_cs, ram_we, ram_oe, ram_wdata_en}), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        mon_en = 1'b1;
        rst = 1'b0;

        // Preload RAM through the CPU port
        access(1'b0, 1'b1, 13'h0010, 8'h33, 2, 8'h00, "pre10");
        access(1'b0, 1'b1, 13'h0020, 8'h44, 2, 8'h00, "pre20");
        access(1'b0, 1'b1, 13'h0030, 8'h77, 2, 8'h00, "pre30");
        access(1'b0, 1'b1, 13'h0040, 8'h12, 2, 8'h00, "pre40");

        // Simultaneous requests right after reset: PPU wins the first tie
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0020;
        ppu_req = 1'b1; ppu_addr = 13'h0010;
        ppu_cyc = 0;
        cpu_cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ppu_ack && ppu_cyc == 0) begin
                ppu_cyc = i;
                ppu_req = 1'b0;
            end
            if (cpu_ack && cpu_cyc == 0) begin
                cpu_cyc = i;
                cpu_req = 1'b0;
            end
            if (ppu_cyc != 0 && cpu_cyc != 0) break;
        end
        chk("tie_ppu_ack_cycle", 32'(ppu_cyc), 32'd3);
        chk("tie_cpu_ack_cycle", 32'(cpu_cyc), 32'd6);
        chk("tie_ppu_rdata", 32'(ppu_rdata), 32'h33);
        chk("tie_cpu_rdata", 32'(cpu_rdata), 32'h44);

        // Continuous requests from both sides: grants alternate
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0030;
        ppu_req = 1'b1; ppu_addr = 13'h0040;
        cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (ppu_ack) begin
                kinds[cnt] = 1;
                times[cnt] = i;
                cnt++;
            end else if (cpu_ack) begin
                kinds[cnt] = 0;
                times[cnt] = i;
                cnt++;
            end else begin
                n = 0;
            end
            if (cnt == 8) begin
                cpu_req = 1'b0;
                ppu_req = 1'b0;
                break;
            end
        end
        chk("rr_count", 32'(cnt), 32'd8);
        for (int i = 0; i < cnt; i++) begin
            chk($sformatf("rr_kind%0d", i), 32'(kinds[i]), 32'((i % 2 == 0) ? 1 : 0));
            if (i > 0) begin
                chk($sformatf("rr_gap%0d", i), 32'(times[i] - times[i-1]), 32'd3);
            end
        end
        chk("rr_cpu_rdata", 32'(cpu_rdata), 32'h77);
        chk("rr_ppu_rdata", 32'(ppu_rdata), 32'h12);

        // rdata of one port is unaffected by the other port's read
        tick();
        access(1'b1, 1'b0, 13'h0020, 8'h00, 3, 8'h44, "ppu_44");
        access(1'b0, 1'b0, 13'h0030, 8'h00, 3, 8'h77, "cpu_77");
        access(1'b1, 1'b0, 13'h0040, 8'h00, 3, 8'h12, "ppu_12");
        chk("cpu_rdata_held", 32'(cpu_rdata), 32'h77);

        // CPU write then read at 0x1ABC, cycle by cycle
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1ABC; cpu_wdata = 8'h5A;
        tick();
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_strobes", 32'({ram_cs, ram_we, ram_oe, ram_wdata_en}), 32'b1101);
        chk("wr_addr", 32'(ram_addr), 32'h1ABC);
        chk("wr_wdata", 32'(ram_wdata), 32'h5A);
        chk("wr_ack_early", 32'(cpu_ack), 32'd0);
        tick();
        chk("wr_ack", 32'(cpu_ack), 32'd1);
        chk("wr_idle_strobes", 32'({ram_cs, ram_we, ram_oe, ram_wdata_en, busy}), 32'd0);
        chk("wr_keeps_rdata", 32'(cpu_rdata), 32'h77);
        cpu_req = 1'b0;
        tick();
        chk("wr_ack_drop", 32'(cpu_ack), 32'd0);
        chk("wr_no_regrant", 32'(busy), 32'd0);
        cpu_we = 1'b0;
        cpu_req = 1'b1;
        tick();
        chk("rd_addr_strobes", 32'({ram_cs, ram_we, ram_oe, ram_wdata_en}), 32'b1000);
        chk("rd_addr", 32'(ram_addr), 32'h1ABC);
        tick();
        chk("rd_data_strobes", 32'({ram_cs, ram_we, ram_oe, ram_wdata_en}), 32'b1010);
        chk("rd_data_ack_early", 32'(cpu_ack), 32'd0);
        tick();
        chk("rd_ack", 32'(cpu_ack), 32'd1);
        chk("rd_rdata", 32'(cpu_rdata), 32'h5A);
        cpu_req = 1'b0;
        tick();

        // Reset during RD_DATA of a PPU read, then reissue
        ppu_req = 1'b1; ppu_addr = 13'h0010;
        tick();
        tick();
        chk("abort_in_rd_data", 32'(ram_oe), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_ppu_ack", 32'(ppu_ack), 32'd0);
        chk("abort_ppu_rdata", 32'(ppu_rdata), 32'd0);
        chk("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("abort_outputs", 32'({ram_cs, ram_we, ram_oe, ram_wdata_en, busy}), 32'd0);
        chk("abort_ram_addr", 32'(ram_addr), 32'd0);
        tick();
        chk("abort_no_ack", 32'(ppu_ack), 32'd0);
        rst = 1'b0;
        n = 0;
        while (!ppu_ack && n < 20) begin
            tick();
            n++;
        end
        chk("reissue_lat", 32'(n), 32'd3);
        chk("reissue_rdata", 32'(ppu_rdata), 32'h33);
        ppu_req = 1'b0;
        tick();
        tick();

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
